// File: rtl/cache_controller_if.sv
// MEM-stage request bus and SRAM-controller bus of the read cache.
// The cache takes the slave side; the MEM stage / SRAM side is the master.
interface cache_controller_if;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_busy;

  modport master (
    output mem_rd_en, mem_wr_en, address, write_data,
    output sram_read_data, sram_busy,
    input  read_data, ready, sram_rd_en, sram_wr_en,
    input  sram_address, sram_write_data
  );

  modport slave (
    input  mem_rd_en, mem_wr_en, address, write_data,
    input  sram_read_data, sram_busy,
    output read_data, ready, sram_rd_en, sram_wr_en,
    output sram_address, sram_write_data
  );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative write-through, no-write-allocate read cache
// sitting between the MEM stage and the SRAM controller.
module cache_controller #(
  parameter int SETS    = 64,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 11
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_e;

  state_e state_q, state_d;
  logic   sram_rd_en_q, sram_wr_en_q;

  logic [SETS-1:0]  valid0_q, valid1_q, lru_q;
  logic [TAG_W-1:0] tag0_q [SETS];
  logic [TAG_W-1:0] tag1_q [SETS];
  logic [31:0]      data0_q [SETS];
  logic [31:0]      data1_q [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, victim, done;
  logic               ready, fill_we, wr_we, lru_we, lru_d;
  logic               we0, we1;
  logic [31:0]        rdata, wdata;
  logic               unused_addr;

  assign idx = bus.address[INDEX_W+1:2];
  assign tag = bus.address[TAG_W+INDEX_W+1:INDEX_W+2];
  assign unused_addr = ^{bus.address[31:TAG_W+INDEX_W+2],
                         bus.address[1:0]};

  assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);
  assign done = !bus.sram_busy;

  // Prefer an empty way; otherwise evict the one the LRU bit names.
  assign victim = !valid0_q[idx] ? 1'b0 :
                  !valid1_q[idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    rdata   = '0;
    fill_we = 1'b0;
    wr_we   = 1'b0;
    lru_we  = 1'b0;
    lru_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_wr_en) begin
          state_d = WRITE;
        end else if (bus.mem_rd_en) begin
          if (hit0 || hit1) begin
            ready  = 1'b1;
            rdata  = hit1 ? data1_q[idx] : data0_q[idx];
            lru_we = 1'b1;
            lru_d  = hit0;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (!bus.mem_rd_en) begin
          state_d = IDLE;
        end else if (done) begin
          fill_we = 1'b1;
          lru_we  = 1'b1;
          lru_d   = !victim;
          ready   = 1'b1;
          rdata   = bus.sram_read_data;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!bus.mem_wr_en) begin
          state_d = IDLE;
        end else if (done) begin
          ready   = 1'b1;
          state_d = IDLE;
          if (hit0 || hit1) begin
            wr_we  = 1'b1;
            lru_we = 1'b1;
            lru_d  = hit0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign we0   = (fill_we && !victim) || (wr_we && hit0);
  assign we1   = (fill_we && victim) || (wr_we && hit1);
  assign wdata = fill_we ? bus.sram_read_data : bus.write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sram_rd_en_q <= (state_d == FILL);
      sram_wr_en_q <= (state_d == WRITE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (fill_we && !victim) valid0_q[idx] <= 1'b1;
      if (fill_we && victim)  valid1_q[idx] <= 1'b1;
      if (lru_we)             lru_q[idx]    <= lru_d;
    end
  end

  // Tag/data need no reset: a line is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (we0) data0_q[idx] <= wdata;
    if (we1) data1_q[idx] <= wdata;
    if (we0 && fill_we) tag0_q[idx] <= tag;
    if (we1 && fill_we) tag1_q[idx] <= tag;
  end

  assign bus.ready           = ready;
  assign bus.read_data       = rdata;
  assign bus.sram_rd_en      = sram_rd_en_q;
  assign bus.sram_wr_en      = sram_wr_en_q;
  assign bus.sram_address    = bus.address;
  assign bus.sram_write_data = bus.write_data;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: SRAM responder, cycle-level reference
// model of the cache, directed scenarios and randomized traffic.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if bus();

  cache_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int lat_v = 0;
  int cnt   = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // SRAM controller: busy for lat_v cycles of an access, then done.
  always @(posedge clk) begin
    #1;
    if (bus.sram_rd_en || bus.sram_wr_en) begin
      if (cnt == 0) bus.sram_busy = 1'b0;
      else begin
        bus.sram_busy = 1'b1;
        cnt--;
      end
    end else begin
      bus.sram_busy = 1'b1;
      cnt = lat_v;
    end
  end

  // Reference model: per set two lines plus which way to evict next.
  int          ph = 0;
  bit          mv [64][2];
  logic [10:0] mt [64][2];
  logic [31:0] md [64][2];
  bit          ml [64];

  always @(negedge clk) begin
    int i, hw, vw;
    logic [10:0] t;
    logic        e_rdy;
    logic [31:0] e_rd;
    if (rst) begin
      ph = 0;
      for (int s = 0; s < 64; s++) begin
        mv[s][0] = 0;
        mv[s][1] = 0;
        ml[s] = 0;
      end
    end else begin
      i = int'(bus.address[7:2]);
      t = bus.address[18:8];
      hw = -1;
      for (int w = 0; w < 2; w++)
        if (mv[i][w] && mt[i][w] == t) hw = w;
      e_rdy = 0;
      e_rd = 0;
      chk("sram_rd_en", 32'(bus.sram_rd_en), 32'(ph == 1));
      chk("sram_wr_en", 32'(bus.sram_wr_en), 32'(ph == 2));
      chk("sram_address", bus.sram_address, bus.address);
      chk("sram_write_data", bus.sram_write_data, bus.write_data);
      case (ph)
        0: begin
          if (bus.mem_wr_en) ph = 2;
          else if (bus.mem_rd_en) begin
            if (hw >= 0) begin
              e_rdy = 1;
              e_rd = md[i][hw];
              ml[i] = (hw == 0);
            end else ph = 1;
          end
        end
        1: begin
          if (!bus.mem_rd_en) ph = 0;
          else if (!bus.sram_busy) begin
            vw = !mv[i][0] ? 0 : !mv[i][1] ? 1 : int'(ml[i]);
            mv[i][vw] = 1;
            mt[i][vw] = t;
            md[i][vw] = bus.sram_read_data;
            ml[i] = (vw == 0);
            e_rdy = 1;
            e_rd = bus.sram_read_data;
            ph = 0;
          end
        end
        default: begin
          if (!bus.mem_wr_en) ph = 0;
          else if (!bus.sram_busy) begin
            if (hw >= 0) begin
              md[i][hw] = bus.write_data;
              ml[i] = (hw == 0);
            end
            e_rdy = 1;
            ph = 0;
          end
        end
      endcase
      chk("ready", 32'(bus.ready), 32'(e_rdy));
      chk("read_data", bus.read_data, e_rd);
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] sd,
                     input int lat, input int hold,
                     output logic [31:0] rdata, output int cyc,
                     output int rdc, output int wrc, output bit done);
    lat_v = lat;
    @(posedge clk);
    #1;
    bus.mem_rd_en = rd;
    bus.mem_wr_en = wr;
    bus.address = a;
    bus.write_data = wd;
    bus.sram_read_data = sd;
    cyc = 0;
    rdc = 0;
    wrc = 0;
    done = 0;
    rdata = '0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      cyc++;
      rdc += int'(bus.sram_rd_en);
      wrc += int'(bus.sram_wr_en);
      if (bus.ready) begin
        done = 1;
        rdata = bus.read_data;
        break;
      end
    end
    if (!done) begin
      @(posedge clk);
      #1;
      bus.mem_rd_en = 0;
      bus.mem_wr_en = 0;
    end
  endtask

  task automatic idle_n(input int n);
    @(posedge clk);
    #1;
    bus.mem_rd_en = 0;
    bus.mem_wr_en = 0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    bus.mem_rd_en = 0;
    bus.mem_wr_en = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  logic [31:0] rdv;
  int cyc, rdc, wrc, hold;
  bit done;

  initial begin
    bus.mem_rd_en = 0;
    bus.mem_wr_en = 0;
    bus.address = 0;
    bus.write_data = 0;
    bus.sram_read_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_rd_en", 32'(bus.sram_rd_en), 0);
    chk("rst_wr_en", 32'(bus.sram_wr_en), 0);
    chk("rst_read_data", bus.read_data, 0);

    // Miss then hit of 0x100.
    req(1, 0, 32'h100, 0, 32'hDEADBEEF, 4, 100, rdv, cyc, rdc, wrc, done);
    chk("miss_done", 32'(done), 1);
    chk("miss_data", rdv, 32'hDEADBEEF);
    chk("miss_cyc", cyc, 6);
    chk("miss_rdc", rdc, 5);
    req(1, 0, 32'h100, 0, 0, 4, 100, rdv, cyc, rdc, wrc, done);
    chk("hit_cyc", cyc, 1);
    chk("hit_data", rdv, 32'hDEADBEEF);
    chk("hit_rdc", rdc, 0);

    // LRU eviction in set 0.
    do_reset();
    req(1, 0, 32'h000, 0, 32'hA0, 2, 100, rdv, cyc, rdc, wrc, done);
    req(1, 0, 32'h100, 0, 32'hA1, 2, 100, rdv, cyc, rdc, wrc, done);
    req(1, 0, 32'h000, 0, 0, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("lru_hit0_cyc", cyc, 1);
    chk("lru_hit0_data", rdv, 32'hA0);
    req(1, 0, 32'h200, 0, 32'hA2, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("evict_cyc", cyc, 4);
    req(1, 0, 32'h000, 0, 0, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("keep0_cyc", cyc, 1);
    chk("keep0_data", rdv, 32'hA0);
    req(1, 0, 32'h100, 0, 32'hB1, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("evicted_cyc", cyc, 4);
    chk("evicted_data", rdv, 32'hB1);

    // Write hit updates the cached copy.
    do_reset();
    req(1, 0, 32'h100, 0, 32'h55, 1, 100, rdv, cyc, rdc, wrc, done);
    req(0, 1, 32'h100, 32'h12345678, 0, 3, 100, rdv, cyc, rdc, wrc, done);
    chk("wr_done", 32'(done), 1);
    chk("wr_cyc", cyc, 5);
    chk("wr_wrc", wrc, 4);
    chk("wr_rdata", rdv, 0);
    req(1, 0, 32'h100, 0, 0, 1, 100, rdv, cyc, rdc, wrc, done);
    chk("wrhit_cyc", cyc, 1);
    chk("wrhit_data", rdv, 32'h12345678);

    // Write miss does not allocate.
    req(0, 1, 32'h300, 32'hCAFEF00D, 0, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("wrmiss_cyc", cyc, 4);
    chk("wrmiss_wrc", wrc, 3);
    req(1, 0, 32'h300, 0, 32'h77, 1, 100, rdv, cyc, rdc, wrc, done);
    chk("noalloc_cyc", cyc, 3);
    chk("noalloc_rdc", rdc, 2);
    chk("noalloc_data", rdv, 32'h77);

    // Reset in the middle of a fill.
    idle_n(1);
    lat_v = 5;
    @(posedge clk);
    #1;
    bus.mem_rd_en = 1;
    bus.address = 32'h400;
    bus.sram_read_data = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    bus.mem_rd_en = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rstfill_rd_en", 32'(bus.sram_rd_en), 0);
    chk("rstfill_ready", 32'(bus.ready), 0);
    req(1, 0, 32'h400, 0, 32'h99, 1, 100, rdv, cyc, rdc, wrc, done);
    chk("rstfill_miss_cyc", cyc, 3);
    chk("rstfill_miss_rdc", rdc, 2);

    // Both enables: write wins, read does not allocate.
    req(1, 1, 32'h500, 32'h5, 32'h66, 2, 100, rdv, cyc, rdc, wrc, done);
    chk("both_rdc", rdc, 0);
    chk("both_wrc", wrc, 3);
    chk("both_rdata", rdv, 0);
    req(1, 0, 32'h500, 0, 32'h88, 1, 100, rdv, cyc, rdc, wrc, done);
    chk("both_miss_cyc", cyc, 3);

    // Randomized traffic over a few conflicting sets and tags.
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a = ($urandom & 32'hFFF8_0000) | ($urandom_range(0, 3) << 8)
        | ($urandom_range(0, 3) << 2) | ($urandom & 32'h3);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 100;
      req(op < 6 || op == 9, op >= 6, a, $urandom, $urandom,
          $urandom_range(0, 3), hold, rdv, cyc, rdc, wrc, done);
      if (hold == 100) chk("rand_done", 32'(done), 1);
      if ($urandom_range(0, 4) == 0) idle_n(1);
    end

    idle_n(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate read cache between the MEM stage and the SRAM controller. Read hits return in the request cycle with no SRAM traffic. Read misses fetch the word from the SRAM controller and allocate it. Writes always go through to SRAM and update the cached copy on a hit.

## Interface

Parameters:
- SETS, 64: number of sets (power of two).
- INDEX_W, 6: log2(SETS); index = address[INDEX_W+1:2].
- TAG_W, 11: tag = address[TAG_W+INDEX_W+1:INDEX_W+2], i.e. address[18:8] at defaults.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_rd_en  in  1  read request from MEM stage; held until ready.
- mem_wr_en  in  1  write request from MEM stage; held until ready.
- address  in  32  byte address, word-aligned; bits [1:0] ignored.
- write_data  in  32  store data.
- read_data  out  32  load data; valid when ready=1 for a read.
- ready  out  1  request complete this cycle.
- sram_rd_en  out  1  read request to SRAM controller.
- sram_wr_en  out  1  write request to SRAM controller.
- sram_address  out  32  equal to address.
- sram_write_data  out  32  equal to write_data.
- sram_read_data  in  32  word returned by SRAM controller.
- sram_busy  in  1  high while the SRAM access is in progress. The first cycle it is low while a request is held is the completion cycle; sram_read_data is valid in that cycle.

## Operation

- Storage per set, per way: valid bit, TAG_W tag, 32-bit data. One LRU bit per set holds the way to evict next.
- A way hits when it is valid and its tag equals the address tag. Both ways never hold the same tag.
- States: IDLE, FILL, WRITE.
- IDLE, mem_wr_en=1: go to WRITE. mem_wr_en has priority when both enables are high.
- IDLE, mem_rd_en=1, hit:
  - read_data = hit way data; ready=1.
  - lru[index] = other way.
  - Stay in IDLE.
- IDLE, mem_rd_en=1, miss: go to FILL.
- FILL:
  - sram_rd_en=1.
  - On the completion cycle: write the victim way (valid=1, tag, data=sram_read_data).
    - Victim selection: way0 if invalid, else way1 if invalid, else lru[index].
  - In the same cycle: lru[index] = other way than victim; read_data = sram_read_data; ready=1; go to IDLE.
- WRITE:
  - sram_wr_en=1.
  - On the completion cycle, on a hit: the hit way data = write_data; lru[index] = other way.
  - On the completion cycle, on a miss: arrays unchanged.
  - ready=1; go to IDLE.
- Request dropped before completion in FILL or WRITE: return to IDLE. No array update, no ready.
- read_data = 0 whenever the cycle is not a read completion.

## Timing

- Reset values: state IDLE, all valid bits 0, all LRU bits 0. ready=0, sram_rd_en=0, sram_wr_en=0, read_data=0.
- Reset mid-FILL or mid-WRITE: the next cycle is IDLE with enables low; nothing is allocated.
- Read hit latency: 0 cycles; ready is combinational in the request cycle.
- Read miss latency: 1 cycle in IDLE, then the SRAM access. ready rises in the completion cycle. The next cycle is IDLE.
- Write latency: 1 cycle plus the SRAM access. Writes never complete in 0 cycles.
- sram_rd_en and sram_wr_en are registered state decodes and are never both high.
- Back-to-back: a new request may arrive the cycle after ready. A read of the just-filled address hits.
- sram_address and sram_write_data are combinational pass-through.
- ready depends combinationally on sram_busy in FILL and WRITE.

## Test plan

- Reset, then read 0x00000100 with sram_busy high for 4 cycles (data 0xDEADBEEF):
  - sram_rd_en is high from cycle 1.
  - ready=1 with read_data=0xDEADBEEF at completion.
  - Re-read of 0x100: ready in the same cycle, no sram_rd_en.
- Three addresses mapping to set 0 (0x000, 0x100, 0x200):
  - After reading 0x000, 0x100, then 0x000 again, reading 0x200 evicts 0x100.
  - Read 0x000 then hits; read 0x100 then misses.
- Write hit: fill 0x100, then write 0x12345678.
  - sram_wr_en is asserted until completion.
  - A subsequent read of 0x100 hits and returns 0x12345678.
- Write miss to 0x300:
  - Goes through to SRAM with ready at completion.
  - The next read of 0x300 misses (sram_rd_en asserted).
- rst pulsed during FILL:
  - The next cycle shows sram_rd_en=0 and ready=0.
  - A re-read of the same address misses.
- mem_rd_en and mem_wr_en high together: only sram_wr_en is asserted; the read does not allocate.
